// File: rtl/chip8_draw_controller.sv
// CHIP-8 DRW/CLS engine: XOR-blits sprites from program memory into a 64x32
// one-bit framebuffer (256 bytes, MSB = leftmost pixel) and reports VF.
module chip8_draw_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        cmd_clear,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic [3:0]  n,
  input  logic [11:0] i_addr,
  output logic [11:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  fb_addr,
  input  logic [7:0]  fb_rdata,
  output logic        fb_we,
  output logic [7:0]  fb_wdata,
  output logic        busy,
  output logic        done,
  output logic        collision
);
  typedef enum logic [2:0] {IDLE, CLR, FETCH, RD_L, WR_L, RD_R, WR_R, DONE} state_t;

  state_t      state, state_next;
  logic [5:0]  x_l;
  logic [4:0]  y_l;
  logic [3:0]  n_l, row;
  logic [11:0] i_l;
  logic [7:0]  clr_cnt, s_q;
  logic [11:0] mem_addr_q;
  logic [7:0]  fb_addr_q, fb_wdata_q;
  logic        coll_q, coll_set, accept, last;
  logic [15:0] spread;
  logic [7:0]  spr_l, spr_r;
  logic [4:0]  row_y;
  logic        unused_bits;

  assign unused_bits = ^{x[7:6], y[7:5]};
  assign accept      = (state == IDLE) && start;
  assign last        = (row == n_l - 4'd1);
  assign row_y       = y_l + 5'(row);
  // Shifting the byte across a 16-bit window yields both halves of a
  // misaligned sprite row at once: left byte on top, spill-over below.
  assign spread      = {s_q, 8'h00} >> x_l[2:0];
  assign spr_l       = spread[15:8];
  assign spr_r       = spread[7:0];
  assign collision   = coll_q;

  always_comb begin
    state_next = state;
    mem_addr   = mem_addr_q;
    fb_addr    = fb_addr_q;
    fb_wdata   = fb_wdata_q;
    fb_we      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    coll_set   = 1'b0;
    case (state)
      IDLE:
        if (start) begin
          if (cmd_clear)    state_next = CLR;
          else if (n != 0)  state_next = FETCH;
          else              state_next = DONE;
        end
      CLR: begin
        busy     = 1'b1;
        fb_we    = 1'b1;
        fb_addr  = clr_cnt;
        fb_wdata = 8'h00;
        if (clr_cnt == 8'hFF) state_next = DONE;
      end
      FETCH: begin
        busy       = 1'b1;
        mem_addr   = i_l + 12'(row);
        state_next = RD_L;
      end
      RD_L: begin
        busy       = 1'b1;
        fb_addr    = {row_y, x_l[5:3]};
        state_next = WR_L;
      end
      WR_L: begin
        busy     = 1'b1;
        fb_we    = 1'b1;
        fb_addr  = {row_y, x_l[5:3]};
        fb_wdata = fb_rdata ^ spr_l;
        coll_set = |(fb_rdata & spr_l);
        if (x_l[2:0] != 3'd0) state_next = RD_R;
        else if (last)        state_next = DONE;
        else                  state_next = FETCH;
      end
      RD_R: begin
        busy       = 1'b1;
        fb_addr    = {row_y, x_l[5:3] + 3'd1};
        state_next = WR_R;
      end
      WR_R: begin
        busy       = 1'b1;
        fb_we      = 1'b1;
        fb_addr    = {row_y, x_l[5:3] + 3'd1};
        fb_wdata   = fb_rdata ^ spr_r;
        coll_set   = |(fb_rdata & spr_r);
        state_next = last ? DONE : FETCH;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      x_l        <= '0;
      y_l        <= '0;
      n_l        <= '0;
      i_l        <= '0;
      row        <= '0;
      clr_cnt    <= '0;
      s_q        <= '0;
      coll_q     <= 1'b0;
      mem_addr_q <= '0;
      fb_addr_q  <= '0;
      fb_wdata_q <= '0;
    end else begin
      state      <= state_next;
      mem_addr_q <= mem_addr;
      fb_addr_q  <= fb_addr;
      fb_wdata_q <= fb_wdata;
      if (accept) begin
        x_l     <= x[5:0];
        y_l     <= y[4:0];
        n_l     <= n;
        i_l     <= i_addr;
        row     <= '0;
        clr_cnt <= '0;
        coll_q  <= 1'b0;
      end else begin
        if (state == CLR)  clr_cnt <= clr_cnt + 8'd1;
        if (state == RD_L) s_q <= mem_rdata;
        if (coll_set)      coll_q <= 1'b1;
        if ((state == WR_L || state == WR_R) && state_next == FETCH) row <= row + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_chip8_draw_controller.sv
// Bench for chip8_draw_controller: command table with a pixel-level reference
// model feeding a framebuffer-write scoreboard, plus reset/overlap sequences.
module tb_chip8_draw_controller;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, cmd_clear = 1'b0;
  logic [7:0]  x = '0, y = '0;
  logic [3:0]  n = '0;
  logic [11:0] i_addr = '0;
  logic [11:0] mem_addr;
  logic [7:0]  mem_rdata, fb_addr, fb_rdata, fb_wdata;
  logic        fb_we, busy, done, collision;

  logic [7:0]  mem [4096];
  logic [7:0]  fb  [256];
  logic [7:0]  fbm [256];
  logic [15:0] exp_q [$];
  logic [15:0] mon_e;
  int tests = 0, fails = 0;

  typedef struct {
    bit          clr;
    logic [7:0]  x, y;
    logic [3:0]  n;
    logic [11:0] ia;
    int          lat;
    int          coll;   // -1: take the reference model's answer only
    int          poke;   // cycle at which a stray start is injected, 0 = none
  } vec_t;
  vec_t vt [9];

  chip8_draw_controller dut (
    .clk(clk), .reset(reset), .start(start), .cmd_clear(cmd_clear),
    .x(x), .y(y), .n(n), .i_addr(i_addr),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .fb_addr(fb_addr), .fb_rdata(fb_rdata), .fb_we(fb_we), .fb_wdata(fb_wdata),
    .busy(busy), .done(done), .collision(collision)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    fb_rdata  <= fb[fb_addr];
    if (fb_we) fb[fb_addr] <= fb_wdata;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (fb_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected", fb_addr, fb_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("fb_write", {16'h0, fb_addr, fb_wdata}, {16'h0, mon_e});
      end
    end
  end

  task automatic model_clear();
    for (int a = 0; a < 256; a++) begin
      fbm[a] = 8'h00;
      exp_q.push_back({8'(a), 8'h00});
    end
  endtask

  task automatic model_draw(input logic [7:0] vx, vy, input logic [3:0] vn,
                            input logic [11:0] ia, output bit c);
    logic [7:0] s;
    int px, py, a, bit_i;
    c = 0;
    for (int r = 0; r < int'(vn); r++) begin
      s  = mem[(int'(ia) + r) % 4096];
      py = (int'(vy) + r) % 32;
      for (int b = 0; b < 8; b++) begin
        if (s[7-b]) begin
          px    = (int'(vx) + b) % 64;
          a     = py * 8 + px / 8;
          bit_i = 7 - px % 8;
          if (fbm[a][bit_i]) c = 1;
          fbm[a][bit_i] = ~fbm[a][bit_i];
        end
      end
      a = py * 8 + (int'(vx) % 64) / 8;
      exp_q.push_back({8'(a), fbm[a]});
      if (int'(vx) % 8 != 0) begin
        a = py * 8 + ((int'(vx) % 64) / 8 + 1) % 8;
        exp_q.push_back({8'(a), fbm[a]});
      end
    end
  endtask

  function automatic int fb_diffs();
    int d = 0;
    for (int a = 0; a < 256; a++) if (fb[a] !== fbm[a]) d++;
    return d;
  endfunction

  task automatic run_cmd(input int id, input vec_t v);
    bit mcoll;
    int got, bad_busy;
    mcoll = 0;
    if (v.clr) model_clear();
    else       model_draw(v.x, v.y, v.n, v.ia, mcoll);
    @(negedge clk);
    start = 1'b1; cmd_clear = v.clr; x = v.x; y = v.y; n = v.n; i_addr = v.ia;
    @(posedge clk);
    got = -1;
    bad_busy = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == 1) begin
        cmd_clear = 1'($urandom); x = 8'($urandom); y = 8'($urandom);
        n = 4'($urandom); i_addr = 12'($urandom);
      end
      start = (k == v.poke);
      if (k == v.poke) cmd_clear = 1'b1;
      if (done === 1'b1) begin
        got = k;
        if (busy !== 1'b0) bad_busy++;
        break;
      end
      if (busy !== 1'b1) bad_busy++;
    end
    check($sformatf("latency[%0d]", id), got, v.lat);
    check($sformatf("busy_profile[%0d]", id), bad_busy, 0);
    check($sformatf("collision_model[%0d]", id), {31'h0, collision}, {31'h0, mcoll});
    if (v.coll >= 0) check($sformatf("collision_const[%0d]", id), {31'h0, collision}, v.coll);
    @(negedge clk);
    start = 1'b0;
    check($sformatf("idle_after_done[%0d]", id), {30'h0, busy, done}, 0);
    check($sformatf("collision_held[%0d]", id), {31'h0, collision}, {31'h0, mcoll});
    check($sformatf("writes_left[%0d]", id), exp_q.size(), 0);
    check($sformatf("fb_contents[%0d]", id), fb_diffs(), 0);
    exp_q.delete();
  endtask

  initial begin
    int dcount;
    for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
    mem[12'h200] = 8'hF0;
    mem[12'h300] = 8'hFF;
    mem[12'hFFF] = 8'hC0;
    mem[12'h000] = 8'h80;
    mem[12'h400] = 8'h81; mem[12'h401] = 8'h42; mem[12'h402] = 8'h24; mem[12'h403] = 8'h18;

    //          clr  x      y      n     ia       lat  coll poke
    vt[0] = '{1'b1, 8'd0,  8'd0,  4'd0, 12'h000, 257,  0, 0};
    vt[1] = '{1'b0, 8'd8,  8'd0,  4'd1, 12'h200,   4,  0, 0};
    vt[2] = '{1'b0, 8'd8,  8'd0,  4'd1, 12'h200,   4,  1, 4};
    vt[3] = '{1'b0, 8'd5,  8'd9,  4'd0, 12'h123,   1,  0, 0};
    vt[4] = '{1'b1, 8'd0,  8'd0,  4'd0, 12'h000, 257,  0, 0};
    vt[5] = '{1'b0, 8'd3,  8'd2,  4'd1, 12'h300,   6,  0, 0};
    vt[6] = '{1'b0, 8'd62, 8'd31, 4'd2, 12'hFFF,  11,  0, 0};
    vt[7] = '{1'b0, 8'd0,  8'd0,  4'd4, 12'h400,  13, -1, 5};
    vt[8] = '{1'b0, 8'hC5, 8'h3E, 4'd15, 12'h7F8, 76, -1, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {28'h0, busy, done, fb_we, collision}, 0);
    check("reset_addrs", {12'h0, mem_addr, fb_addr}, 0);
    check("reset_wdata", {24'h0, fb_wdata}, 0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_cmd(i, vt[i]);
      if (i == 1) check("hold_addrs_aligned", {12'h0, mem_addr, fb_addr}, {12'h0, 12'h200, 8'h01});
      if (i == 1) check("aligned_byte", {24'h0, fb[8'h01]}, 32'hF0);
      if (i == 2) check("collision_erase", {24'h0, fb[8'h01]}, 32'h00);
      if (i == 5) check("unaligned_bytes", {16'h0, fb[8'h10], fb[8'h11]}, 32'h1FE0);
      if (i == 6) check("wrap_bytes", {16'h0, fb[8'hFF], fb[8'h07]}, 32'h0302);
      if (i == 6) check("wrap_mem_addr", {20'h0, mem_addr}, 32'h000);
    end

    // Reset lands in cycle 5 of a clear: five writes, then silence.
    for (int a = 0; a < 5; a++) begin
      fbm[a] = 8'h00;
      exp_q.push_back({8'(a), 8'h00});
    end
    @(negedge clk);
    start = 1'b1; cmd_clear = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 5) reset = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    check("abort_busy_we", {30'h0, busy, fb_we}, 0);
    reset = 1'b0;
    dcount = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done === 1'b1 || fb_we === 1'b1) dcount++;
    end
    check("abort_no_done", dcount, 0);
    check("abort_writes_left", exp_q.size(), 0);
    check("abort_fb", fb_diffs(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
